// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; by default data always wins over fetch.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,  // legal range 1..4
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CntW = 2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gnt_data_q, gnt_data_d;  // 1 = data port owns the transaction
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_data;

`ifdef MEM_ARB_RR_EN
  logic last_data_q, last_data_d;  // 0 = fetch was granted last
  assign pick_data = d_req & (~if_req | ~last_data_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (if_req | d_req) begin
          gnt_data_d = pick_data;
          we_d       = pick_data & d_we;
          addr_d     = pick_data ? d_addr : if_addr;
          wdata_d    = pick_data ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_data_d = pick_data;
`endif
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          cnt_d   = CntW'(MEM_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (gnt_data_q) d_rdata_d = mem_rdata;
          else            if_rdata_d = mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Strobes and acks are masked during reset so an aborted transaction never completes.
  assign mem_en    = (state_q == StIssue) & ~RST;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == StDone) & ~gnt_data_q & ~RST;
  assign d_ack     = (state_q == StDone) & gnt_data_q & ~RST;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_ack;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a cycle-count reference model.
module tb_mem_arbiter;
  localparam int unsigned LAT = 2;
  localparam int unsigned PW  = LAT * 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_stall, d_ack, mem_en, mem_we, busy;

  always #5 CLK = ~CLK;

  mem_arbiter #(.MEM_LAT(LAT), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'h04) return 32'h00A0_0093;
    return {8'hC0, idx, ~idx, idx ^ 8'h5A};
  endfunction

  // Memory: read data appears exactly LAT cycles after the mem_en cycle, X at all other times.
  logic [31:0] mem [256];
  bit          written [256];
  logic [PW-1:0] rd_pipe;
  assign mem_rdata = rd_pipe[PW-1 -: 32];

  always @(posedge CLK) begin
    if (mem_en && !mem_we)
      rd_pipe <= PW'({rd_pipe, (written[mem_addr[9:2]] ? mem[mem_addr[9:2]]
                                                       : init_word(mem_addr[9:2]))});
    else
      rd_pipe <= PW'({rd_pipe, 32'hxxxx_xxxx});
    if (mem_en && mem_we) begin
      mem[mem_addr[9:2]]     <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          act, w_d, w_we, last_d, chk_en, rst_now, rnd_rst;
  int          g_cyc, a_cyc, n;
  logic [31:0] w_addr, w_wdata, w_rval, e_if_rdata, e_d_rdata, e_maddr;
  bit          ip, dp, dwe;
  logic [31:0] ia, da, dwd;
  logic [31:0] shadow [256];
  logic [3:0]  ord;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit pick_data();
`ifdef MEM_ARB_RR_EN
    return dp && (!ip || !last_d);
`else
    return dp;
`endif
  endfunction

  // Expected outputs follow from the grant cycle and fixed latencies alone.
  task automatic check_outputs();
    bit e_en, e_iack, e_dack;
    e_en   = act && (cyc == g_cyc + 1);
    e_iack = act && (cyc == a_cyc) && !w_d;
    e_dack = act && (cyc == a_cyc) && w_d;
    chk1("busy", busy, act);
    chk1("mem_en", mem_en, e_en);
    chk1("mem_we", mem_we, e_en && w_we);
    chk32("mem_addr", mem_addr, e_maddr);
    if (e_en && w_we) chk32("mem_wdata", mem_wdata, w_wdata);
    chk1("if_ack", if_ack, e_iack);
    chk1("d_ack", d_ack, e_dack);
    chk32("if_rdata", if_rdata, e_if_rdata);
    chk32("d_rdata", d_rdata, e_d_rdata);
    chk1("if_stall", if_stall, ip && !e_iack);
  endtask

  task automatic model_edge(input bit rst);
    if (rst) begin
      act = 0; last_d = 0;
      e_if_rdata = '0; e_d_rdata = '0; e_maddr = '0;
    end else if (!act) begin
      if (ip || dp) begin
        w_d     = pick_data();
        act     = 1;
        g_cyc   = cyc;
        w_we    = w_d && dwe;
        w_addr  = w_d ? da : ia;
        w_wdata = dwd;
        a_cyc   = cyc + (w_we ? 2 : 2 + int'(LAT));
        e_maddr = w_addr;
        last_d  = w_d;
        if (w_we) shadow[w_addr[9:2]] = w_wdata;
        else      w_rval = shadow[w_addr[9:2]];
      end
    end else if (cyc == a_cyc) begin
      act = 0;
      if (w_d) dp = 0;
      else     ip = 0;
    end
    cyc++;
    if (act && cyc == a_cyc && !w_we) begin
      if (w_d) e_d_rdata = w_rval;
      else     e_if_rdata = w_rval;
    end
  endtask

  task automatic step(input bit rst);
    rst_now = rst;
    RST = rst; if_req = ip; if_addr = ia;
    d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge CLK);
    if (chk_en && !rst) check_outputs();
  endtask

  task automatic adv();
    @(posedge CLK);
    model_edge(rst_now);
    #1;
  endtask

  task automatic do_reset();
    ip = 0; dp = 0;
    step(1); adv();
  endtask

  initial begin
    chk_en = 0; ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
    for (int i = 0; i < 256; i++) shadow[8'(i)] = init_word(8'(i));
    do_reset();
    do_reset();
    chk_en = 1;

    // Reset state
    step(0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    adv();

    // Fetch of 0x10
    ip = 1; ia = 32'h10;
    for (int k = 0; k <= 4; k++) begin
      step(0);
      if (k == 1) begin
        chk1("fetch_en", mem_en, 1'b1);
        chk32("fetch_addr", mem_addr, 32'h10);
      end
      if (k == 4) begin
        chk1("fetch_ack", if_ack, 1'b1);
        chk32("fetch_data", if_rdata, 32'h00A0_0093);
      end
      adv();
    end

    // Store then load back
    dp = 1; dwe = 1; da = 32'h40; dwd = 32'hDEAD_BEEF;
    for (int k = 0; k <= 2; k++) begin
      step(0);
      if (k == 1) begin
        chk1("store_en", mem_en, 1'b1);
        chk1("store_we", mem_we, 1'b1);
        chk32("store_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (k == 2) chk1("store_ack", d_ack, 1'b1);
      adv();
    end
    dp = 1; dwe = 0; dwd = '0;
    for (int k = 0; k <= 4; k++) begin
      step(0);
      if (k == 3) chk1("load_early", d_ack, 1'b0);
      if (k == 4) begin
        chk1("load_ack", d_ack, 1'b1);
        chk32("load_data", d_rdata, 32'hDEAD_BEEF);
      end
      adv();
    end

    // Simultaneous fetch and load right after reset: data first
    do_reset();
    ip = 1; ia = 32'h10; dp = 1; dwe = 0; da = 32'h44;
    for (int k = 0; k <= 9; k++) begin
      step(0);
      chk1("conf_stall", if_stall, k <= 8);
      if (k == 4) begin
        chk1("conf_dack", d_ack, 1'b1);
        chk32("conf_ddata", d_rdata, init_word(8'h11));
      end
      if (k == 9) begin
        chk1("conf_iack", if_ack, 1'b1);
        chk32("conf_idata", if_rdata, 32'h00A0_0093);
      end
      adv();
    end

    // Reset in the wait phase of a fetch, then a clean fetch
    ip = 1; ia = 32'h10;
    step(0); adv();
    step(0); adv();
    ip = 0;
    step(1); adv();
    step(0);
    chk1("abort_iack", if_ack, 1'b0);
    chk1("abort_en", mem_en, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_stall", if_stall, 1'b0);
    chk32("abort_addr", mem_addr, 32'h0);
    chk32("abort_rdata", if_rdata, 32'h0);
    adv();
    ip = 1; ia = 32'h20;
    for (int k = 0; k <= 4; k++) begin
      step(0);
      if (k == 3) chk1("refetch_early", if_ack, 1'b0);
      if (k == 4) begin
        chk1("refetch_ack", if_ack, 1'b1);
        chk32("refetch_data", if_rdata, init_word(8'h08));
      end
      adv();
    end

    // Both ports held continuously: grant order per arbitration mode
    do_reset();
`ifdef MEM_ARB_RR_EN
    ord = 4'b0101;  // bit n = 1 when the n-th grant goes to data
`else
    ord = 4'b1111;
`endif
    ip = 1; ia = 32'h30; dp = 1; dwe = 0; da = 32'h48;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step(0);
      if (if_ack || d_ack) begin
        chk1("grant_order", d_ack, ord[2'(n)]);
        n++;
      end
      adv();
      ip = 1; dp = 1;
    end
    chk32("grant_count", 32'(n), 32'd4);

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rnd_rst = ($urandom_range(0, 199) == 0);
      if (rnd_rst) begin
        ip = 0; dp = 0;
      end else begin
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1; ia = 32'($urandom_range(0, 15)) << 2;
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; dwe = 1'($urandom); da = 32'($urandom_range(0, 15)) << 2; dwd = $urandom;
        end
      end
      step(rnd_rst); adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles from mem_en issue to mem_rdata valid; legal range 1..4.
REQ-002 Parameter DATA_W, default 32, data and address width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr stable until if_ack.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_rdata  output  32  fetched instruction; valid while if_ack=1.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 if_stall  output  1  combinational if_req & ~if_ack; freezes the program counter.
REQ-010 d_req  input  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr, d_wdata  input  32 each  data address and store data.
REQ-013 d_rdata  output  32  load result; valid while d_ack=1.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 mem_en, mem_we  output  1 each  single-port memory strobe and write enable.
REQ-016 mem_addr, mem_wdata  output  32 each  registered memory address and write data.
REQ-017 mem_rdata  input  32  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-018 busy  output  1  high whenever the FSM state is not IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-020 IDLE: when any request is high at the clock edge, the block SHALL latch the winner's address, data, write enable and identity, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-021 ISSUE: the block SHALL assert mem_en for exactly one cycle from the latched registers, with mem_we=1 only for a store.
REQ-022 From ISSUE, a store SHALL go to DONE, and a load or fetch SHALL go to WAIT with the wait counter set to MEM_LAT-1.
REQ-023 WAIT: the counter SHALL decrement each cycle; at count 0 mem_rdata SHALL be captured and the FSM SHALL go to DONE.
REQ-024 DONE: the block SHALL assert the winner's ack for one cycle, drive rdata for a read, and then return to IDLE.
REQ-025 Latency: request sampled in cycle 0 -> load or fetch ack in cycle 2+MEM_LAT; store ack in cycle 2.
REQ-026 Requesters SHALL drop req in the cycle after ack unless issuing a new request; a req still high in IDLE is a new transaction.
REQ-027 Default priority: when both requests are high in IDLE, data SHALL win and the fetch SHALL wait with if_stall=1.
REQ-028 Requests that arrive or change while not in IDLE SHALL be ignored until the next IDLE cycle; the latched transaction SHALL be unaffected.
REQ-029 if_rdata and d_rdata SHALL hold their last captured value between acks; acks SHALL never be high together.
REQ-030 mem_en SHALL be high at most one cycle per transaction.

Reset
REQ-031 With RST=1 at an edge: state=IDLE; counter, mem_en, mem_we, if_ack, d_ack, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
REQ-032 Reset during ISSUE, WAIT or DONE SHALL abort the transaction with no ack and no further mem_en; a pending ack SHALL be suppressed.
REQ-033 The block SHALL sample no request in a cycle where RST=1; arbitration SHALL resume in the first cycle after RST falls.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: round-robin arbitration; a last_grant flag (reset 0 = fetch) SHALL give the other requester priority on conflict, so each requester is served within two transactions.
REQ-035 MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-027, with no last_grant state.

Verification (MEM_LAT=2)
REQ-036 Fetch: if_req=1, if_addr=0x10, memory word 0x00A0_0093 -> mem_en in cycle 1 with mem_addr=0x10; if_ack=1 and if_rdata=0x00A0_0093 in cycle 4.
REQ-037 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_en=mem_we=1 in cycle 1; d_ack in cycle 2; a following load of 0x40 returns 0xDEAD_BEEF.
REQ-038 Conflict, fixed priority: if_req and d_req (load 0x44) rise together -> d_ack in cycle 4; fetch granted in cycle 5 with if_ack in cycle 9; if_stall=1 in cycles 0-8.
REQ-039 Conflict, MEM_ARB_RR_EN, both held continuously -> grant order data, fetch, data, fetch with no back-to-back grants to one side.
REQ-040 RST=1 in cycle 2 of a fetch -> no if_ack, mem_en=0, and all outputs zero in cycle 3; a new fetch after reset completes with normal latency.
